// File: rtl/mips_data_memory_ctrl.sv
// Data memory for the MIPS MEM stage. Valid/ready request channel and a held response channel.
// Byte/half/word access, configurable latency, alignment and range checking.
module mips_data_memory_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_req_ready, w_req_ready_nxt;
  logic        r_resp_valid, w_resp_valid_nxt;
  logic [31:0] r_rdata, w_rdata_nxt;
  logic        r_err, w_err_nxt;

  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic             w_accept;
  logic             w_access;
  logic             w_err;
  logic             w_mem_we;
  logic [31:0]      w_offset;
  logic [IDX_W-1:0] w_idx;
  logic [3:0]       w_be;
  logic [31:0]      w_wlanes;
  logic [31:0]      w_word;
  logic [31:0]      w_load;

  function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr,
                                      input logic [31:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      2'b01:   bad = addr[0];
      2'b10:   bad = (addr[1:0] != 2'b00);
      2'b11:   bad = 1'b1;
      default: bad = 1'b0;
    endcase
    // Unsigned compare: addresses below BASE_ADDR wrap to huge offsets and fail here too.
    return bad || (offset >= SPAN);
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the store data puts it on every lane; the mask picks the right one.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic sgn,
                                              input logic [1:0] lane, input logic [31:0] word);
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    sh_b = word >> {lane, 3'b000};
    sh_h = word >> {lane[1], 4'b0000};
    case (size)
      2'b00:   return sgn ? {{24{sh_b[7]}}, sh_b[7:0]} : {24'h0, sh_b[7:0]};
      2'b01:   return sgn ? {{16{sh_h[15]}}, sh_h[15:0]} : {16'h0, sh_h[15:0]};
      default: return word;
    endcase
  endfunction

  assign w_accept = (r_state == IDLE) && r_req_ready && req_valid_i;
  assign w_access = (r_state == BUSY) && (r_cnt == 4'd0);
  assign w_offset = r_addr - BASE_ADDR;
  assign w_idx    = w_offset[IDX_W+1:2];
  assign w_err    = access_err(r_size, r_addr, w_offset);
  assign w_be     = lane_mask(r_size, r_addr[1:0]);
  assign w_wlanes = lane_data(r_size, r_wdata);
  assign w_word   = r_mem[w_idx];
  assign w_load   = load_extend(r_size, r_signed, r_addr[1:0], w_word);
  // State is forced to IDLE by reset, so a store aborted in BUSY never reaches the array.
  assign w_mem_we = w_access && r_write && !w_err;

  // Request capture: data only, enabled by acceptance
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write  <= req_write_i;
      r_size   <= req_size_i;
      r_signed <= req_signed_i;
      r_addr   <= req_addr_i;
      r_wdata  <= req_wdata_i;
    end
  end

  // Array write at the access edge
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_req_ready_nxt  = r_req_ready;
    w_resp_valid_nxt = r_resp_valid;
    w_rdata_nxt      = r_rdata;
    w_err_nxt        = r_err;
    case (r_state)
      IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (w_accept) begin
          w_req_ready_nxt = 1'b0;
          w_cnt_nxt       = CNT_INIT;
          w_state_nxt     = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt      = RESP;
          w_resp_valid_nxt = 1'b1;
          w_err_nxt        = w_err;
          w_rdata_nxt      = (w_err || r_write) ? 32'h0 : w_load;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP: begin
        if (r_resp_valid && resp_ready_i) begin
          w_resp_valid_nxt = 1'b0;
          w_rdata_nxt      = 32'h0;
          w_err_nxt        = 1'b0;
          w_req_ready_nxt  = 1'b1;
          w_state_nxt      = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata      <= 32'h0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_rdata      <= w_rdata_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign req_ready_o  = r_req_ready;
  assign resp_valid_o = r_resp_valid;
  assign resp_rdata_o = r_rdata;
  assign resp_err_o   = r_err;

endmodule

// File: doc/mips_data_memory_ctrl.md
Name: mips_data_memory_ctrl

Overview:
Parametrised data-memory block for the MIPS core's MEM stage. It replaces the bare data_memory with a valid/ready request channel and a response channel. It supports byte, half-word and word loads and stores with sign or zero extension, alignment and range checking, and a configurable access latency. One request is outstanding at a time, so the pipeline stalls (stall_e/stall_m) on req_ready_o and resp_valid_o.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words stored; power of two, at least 4.
LATENCY, 1, cycles from request acceptance to response valid; legal range 1..15.
BASE_ADDR, 32'h1000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
req_valid_i  input  1  request present.
req_ready_o  output  1  block can accept a request.
req_write_i  input  1  1 = store, 0 = load.
req_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal.
req_signed_i  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
req_addr_i  input  32  byte address.
req_wdata_i  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
resp_valid_o  output  1  response present.
resp_ready_i  input  1  consumer takes the response.
resp_rdata_o  output  32  load result; 0 for stores and errors.
resp_err_o  output  1  request was misaligned, out of range or illegal size.

Behaviour:
- Clocking and reset: one clock (clk). Reset rst_n is asynchronous and active-low. While rst_n=0: FSM=IDLE, req_ready_o=0, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, latency counter=0.
  - Memory array contents are not reset. Power-up contents are undefined; the bench writes before reading.
  - req_ready_o is registered. It goes to 1 on the first rising edge after rst_n deasserts.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: req_ready_o=1. On req_valid_i & req_ready_o at edge N, capture write, size, signed, addr and wdata into request registers, load counter with LATENCY-1, go to BUSY. req_ready_o drops to 0 after edge N.
  - BUSY: counter decrements each edge. At the edge where counter==0 (edge N+LATENCY), perform the access, register the results, set resp_valid_o=1 and go to RESP.
  - RESP: hold resp_valid_o, resp_rdata_o and resp_err_o stable until resp_valid_o & resp_ready_i, then clear resp_valid_o, resp_rdata_o and resp_err_o and go to IDLE. req_ready_o returns to 1 on that same edge. There is no acceptance in the handshake cycle, so minimum spacing is LATENCY+2 cycles per request.
- Request inputs are don't-care when not accepted. Captured values are immune to later input changes.
- Address decode: offset = addr - BASE_ADDR. In range iff offset < DEPTH_WORDS*4, using unsigned 32-bit compare with wrap. Word index = offset[log2(DEPTH_WORDS)+1:2].
- Error conditions, any of:
  - size==11;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=00;
  - out of range.
  - On error: no array write, resp_err_o=1, resp_rdata_o=0.
- Stores: little-endian lanes.
  - Byte writes lane addr[1:0] with wdata[7:0].
  - Half writes lanes {addr[1],0}+1 and {addr[1],0} with wdata[15:0].
  - Word writes all lanes. Other lanes are untouched.
  - resp_rdata_o=0, resp_err_o=0.
- Loads: extract the byte or half from the addressed lane. Extend to 32 bits with bit 7 or 15 when req_signed_i=1, else with zeros. For word loads req_signed_i is ignored.
- Ordering: a store completes before its response. A load issued after a store's response always sees the stored data.
- Reset mid-operation (BUSY or RESP): the transaction is aborted and FSM returns to IDLE.
  - A store aborted in BUSY is not written.
  - A store whose response was already valid has already been written.

Test Plan:
- LATENCY=1, reset release -> req_ready_o=0 during reset, 1 after first edge. Store word 0xDEADBEEF to 0x1000_0004, then load word from 0x1000_0004 -> resp_valid_o exactly 1 cycle after accept, rdata=0xDEADBEEF, err=0.
- After the prior store: store byte 0x80 to 0x1000_0005; load signed byte from 0x1000_0005 -> 0xFFFFFF80; unsigned byte -> 0x00000080; load word from 0x1000_0004 -> 0xDEAD80EF.
- Store half 0x1234 to 0x1000_0002 over prior word 0 = 0 -> word load from 0x1000_0000 returns 0x12340000. Signed half load of 0x8001 -> 0xFFFF8001.
- Error cases, each -> err=1, rdata=0, array unchanged:
  - half load from 0x1000_0001;
  - word store to 0x1000_0006;
  - size=11;
  - address 0x0FFF_FFFC;
  - address BASE_ADDR+DEPTH_WORDS*4.
- LATENCY=4, resp_ready_i held 0 for 5 cycles -> response stable and req_ready_o=0 throughout. After the handshake, req_ready_o=1 on the next cycle. Back-to-back requests are spaced at least 6 cycles.
- LATENCY=4, store accepted, then rst_n pulsed low 2 cycles after acceptance -> outputs zero immediately (asynchronous). After re-release, a load of that address returns the old value.
